// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared DHT11 reader types, error codes and default timing
package dht11_pkg;

  localparam int unsigned DEF_CLK_FREQ_HZ   = 50_000_000;
  localparam int unsigned DEF_START_LOW_US  = 18_000;
  localparam int unsigned DEF_TIMEOUT_US    = 100;
  localparam int unsigned DEF_BIT_THRESH_US = 40;

  localparam int unsigned CNT_W     = 15;
  localparam int unsigned BIT_CNT_W = 6;
  localparam int unsigned NUM_BITS  = 40;

  typedef logic [CNT_W-1:0]     cnt_t;
  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START_LOW,
    ST_RELEASE,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK,
    ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK          = 2'b00,
    ERR_NO_RESP     = 2'b01,
    ERR_BIT_TIMEOUT = 2'b10,
    ERR_CHECKSUM    = 2'b11
  } err_e;

  // Frame is MSB-first: byte0 in [39:32], checksum byte in [7:0].
  function automatic logic checksum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - free-running one-cycle tick every microsecond
module us_tick_gen
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = DEF_CLK_FREQ_HZ
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV  = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int unsigned W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/dht11_reader.sv
// rtl/dht11_reader.sv - DHT11 single-wire host: start pulse, 40-bit capture, checksum
module dht11_reader
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = DEF_CLK_FREQ_HZ,
  parameter int unsigned START_LOW_US  = DEF_START_LOW_US,
  parameter int unsigned TIMEOUT_US    = DEF_TIMEOUT_US,
  parameter int unsigned BIT_THRESH_US = DEF_BIT_THRESH_US
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  inout  wire        transmission_line,
  output logic       busy,
  output logic       done,
  output logic [1:0] error_code,
  output logic [7:0] humidity_int,
  output logic [7:0] humidity_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec
);

  localparam cnt_t     START_LAST   = cnt_t'(START_LOW_US - 1);
  localparam cnt_t     TIMEOUT_LAST = cnt_t'(TIMEOUT_US - 1);
  localparam cnt_t     BIT_THRESH   = cnt_t'(BIT_THRESH_US);
  localparam bit_cnt_t LAST_BIT     = bit_cnt_t'(NUM_BITS - 1);

  logic        tick;
  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  bit_cnt_t    bit_cnt_q, bit_cnt_d;
  logic [39:0] shift_q, shift_d;
  err_e        err_q, err_d;
  logic [31:0] data_q, data_d;
  logic        armed_q, armed_d;
  logic        line_s1_q, line_s2_q;
  logic        line_s, timeout;
  cnt_t        high_cnt;

  us_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign transmission_line = (state_q == ST_START_LOW) ? 1'b0 : 1'bz;

  assign line_s   = line_s2_q;
  assign timeout  = tick && (cnt_q == TIMEOUT_LAST);
  // Include this cycle's tick so a pulse of N us always counts exactly N.
  assign high_cnt = cnt_q + cnt_t'(tick);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    err_d     = err_q;
    data_d    = data_q;
    armed_d   = 1'b0;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_START_LOW;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      ST_START_LOW: begin
        if (tick && cnt_q == START_LAST) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Our own drive-low is still in the synchronizer; wait to see the line high first.
        armed_d = armed_q | line_s;
        if (armed_q && !line_s) state_d = ST_RESP_LOW;
        else if (timeout) begin
          state_d = ST_FINISH;
          err_d   = ERR_NO_RESP;
        end
      end
      ST_RESP_LOW: begin
        if (line_s) state_d = ST_RESP_HIGH;
        else if (timeout) begin
          state_d = ST_FINISH;
          err_d   = ERR_NO_RESP;
        end
      end
      ST_RESP_HIGH: begin
        if (!line_s) state_d = ST_BIT_LOW;
        else if (timeout) begin
          state_d = ST_FINISH;
          err_d   = ERR_NO_RESP;
        end
      end
      ST_BIT_LOW: begin
        if (line_s) state_d = ST_BIT_HIGH;
        else if (timeout) begin
          state_d = ST_FINISH;
          err_d   = ERR_BIT_TIMEOUT;
        end
      end
      ST_BIT_HIGH: begin
        if (!line_s) begin
          shift_d   = {shift_q[38:0], (high_cnt > BIT_THRESH)};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
        end else if (timeout) begin
          state_d = ST_FINISH;
          err_d   = ERR_BIT_TIMEOUT;
        end
      end
      ST_CHECK: begin
        state_d = ST_FINISH;
        if (checksum_ok(shift_q)) begin
          data_d = shift_q[39:8];
          err_d  = ERR_OK;
        end else begin
          err_d  = ERR_CHECKSUM;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (state_d != state_q || state_q == ST_IDLE) cnt_d = '0;
    else if (tick)                                cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      err_q     <= ERR_OK;
      data_q    <= '0;
      armed_q   <= 1'b0;
      line_s1_q <= 1'b1;
      line_s2_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      err_q     <= err_d;
      data_q    <= data_d;
      armed_q   <= armed_d;
      line_s1_q <= transmission_line;
      line_s2_q <= line_s1_q;
    end
  end

  assign busy         = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done         = (state_q == ST_FINISH);
  assign error_code   = err_q;
  assign humidity_int = data_q[31:24];
  assign humidity_dec = data_q[23:16];
  assign temp_int     = data_q[15:8];
  assign temp_dec     = data_q[7:0];

endmodule
